// File: rtl/trace_record_downsizer_if.sv
// rtl/trace_record_downsizer_if.sv - wide record input stream and narrow beat output stream
interface trace_record_downsizer_if;
    logic         input_axis_tvalid;
    logic         input_axis_tready;
    logic [127:0] input_axis_tdata;
    logic         output_axis_tvalid;
    logic         output_axis_tready;
    logic [31:0]  output_axis_tdata;
    logic         output_axis_tlast;

    modport slave (
        input  input_axis_tvalid,
        input  input_axis_tdata,
        output input_axis_tready,
        output output_axis_tvalid,
        output output_axis_tdata,
        output output_axis_tlast,
        input  output_axis_tready
    );

    modport master (
        output input_axis_tvalid,
        output input_axis_tdata,
        input  input_axis_tready,
        input  output_axis_tvalid,
        input  output_axis_tdata,
        input  output_axis_tlast,
        output output_axis_tready
    );
endinterface

// File: rtl/trace_record_downsizer.sv
// rtl/trace_record_downsizer.sv - record FIFO plus 128-to-32 serializer, LS word first
// Optional overflow-marked record counter enabled by defining TRACE_OVERFLOW_COUNT_EN.
module trace_record_downsizer #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    trace_record_downsizer_if.slave bus,
    output logic [AW:0]             fifo_level,
    output logic [31:0]             overflow_count
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic [127:0]  shadow_q, shadow_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [127:0]  mem_q [DEPTH];

    logic full, empty, push, pop;

    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign push  = bus.input_axis_tvalid && !full;

    assign bus.input_axis_tready  = !full;
    assign bus.output_axis_tvalid = (state_q == ST_SEND);
    assign bus.output_axis_tdata  = shadow_q[{beat_q, 5'd0} +: 32];
    assign bus.output_axis_tlast  = (state_q == ST_SEND) && (beat_q == 2'd3);
    assign fifo_level             = level_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shadow_d = shadow_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shadow_d = mem_q[rptr_q[AW-1:0]];
                    beat_d   = 2'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.output_axis_tready) begin
                    if (beat_q != 2'd3) begin
                        beat_d = beat_q + 2'd1;
                    end else if (!empty) begin
                        // Chain straight into the next record so beats stay gapless.
                        pop      = 1'b1;
                        shadow_d = mem_q[rptr_q[AW-1:0]];
                        beat_d   = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wptr_d  = wptr_q + {{AW{1'b0}}, push};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    assign level_d = wptr_d - rptr_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            beat_q   <= 2'd0;
            shadow_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            shadow_q <= shadow_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= bus.input_axis_tdata;
        end
    end

`ifdef TRACE_OVERFLOW_COUNT_EN
    logic [31:0] ovf_cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ovf_cnt_q <= '0;
        end else if (push && bus.input_axis_tdata[31] && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 32'd1;
        end
    end

    assign overflow_count = ovf_cnt_q;
`else
    assign overflow_count = 32'h0;
`endif
endmodule

// File: tb/tb_trace_record_downsizer.sv
// tb/tb_trace_record_downsizer.sv - scoreboard bench for trace_record_downsizer
module tb_trace_record_downsizer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [4:0]  fifo_level;
    logic [31:0] overflow_count;

    trace_record_downsizer_if bus ();

    trace_record_downsizer #(.DEPTH(16)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .bus            (bus),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          obs_cyc_q[$];

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && bus.output_axis_tvalid && bus.output_axis_tready) begin
            obs_q.push_back({bus.output_axis_tlast, bus.output_axis_tdata});
            obs_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [127:0] mk(input int i);
        logic [31:0] b;
        b = 32'h1000_0000 + 32'(i) * 32'd16;
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push_exp(input logic [127:0] rec, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            exp_q.push_back({(b == 3), rec[32*b +: 32]});
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        bus.input_axis_tvalid  = 1'b0;
        bus.input_axis_tdata   = '0;
        bus.output_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic send_record(input logic [127:0] rec, output int acc_cyc);
        logic acc;
        acc_cyc = -1;
        bus.input_axis_tvalid = 1'b1;
        bus.input_axis_tdata  = rec;
        for (int t = 0; t < 60; t++) begin
            acc = bus.input_axis_tready;
            if (acc) acc_cyc = cyc;
            @(posedge aclk);
            #1;
            if (acc) break;
        end
        bus.input_axis_tvalid = 1'b0;
        checks++;
        if (acc_cyc < 0) begin
            errors++;
            $display("FAIL send_timeout got no accept want accept");
        end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.input_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_in_tready got %b want 1", bus.input_axis_tready); end
        checks++;
        if (bus.output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", bus.output_axis_tvalid); end
        checks++;
        if (bus.output_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", bus.output_axis_tdata); end
        checks++;
        if (bus.output_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", bus.output_axis_tlast); end
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        checks++;
        if (overflow_count !== 32'h0) begin errors++; $display("FAIL rst_ovf got %0d want 0", overflow_count); end
    endtask

    task automatic test_single();
        int n;
        bit ok;
        logic [32:0] got, exp;
        int gc;
        do_reset();
        bus.output_axis_tready = 1'b1;
        send_record(128'h44444444_33333333_22222222_11111111, n);
        push_exp(128'h44444444_33333333_22222222_11111111, 4);
        wait_obs(4, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout got %0d beats want 4", obs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                got = obs_q.pop_front(); gc = obs_cyc_q.pop_front(); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL single_beat%0d got %h want %h", k, got, exp); end
                checks++;
                if (gc !== n + 2 + k) begin errors++; $display("FAIL single_cycle%0d got %0d want %0d", k, gc, n + 2 + k); end
            end
        end
    endtask

    task automatic test_fill();
        int acc;
        bit a, ok;
        logic [32:0] got, exp;
        int gc, c0;
        do_reset();
        acc = 0;
        for (int i = 0; i < 18; i++) begin
            bus.input_axis_tvalid = 1'b1;
            bus.input_axis_tdata  = mk(i);
            a = bus.input_axis_tready;
            @(posedge aclk);
            #1;
            if (a) begin
                push_exp(mk(i), 4);
                acc++;
            end
        end
        bus.input_axis_tvalid = 1'b0;
        checks++;
        if (acc !== 17) begin errors++; $display("FAIL fill_accepted got %0d want 17", acc); end
        checks++;
        if (bus.input_axis_tready !== 1'b0) begin errors++; $display("FAIL fill_tready got %b want 0", bus.input_axis_tready); end
        checks++;
        if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", fifo_level); end
        bus.output_axis_tready = 1'b1;
        wait_obs(68, 120, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fill_timeout got %0d beats want 68", obs_q.size());
        end else begin
            c0 = obs_cyc_q[0];
            for (int k = 0; k < 68; k++) begin
                got = obs_q.pop_front(); gc = obs_cyc_q.pop_front(); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL fill_beat%0d got %h want %h", k, got, exp); end
                checks++;
                if (gc !== c0 + k) begin errors++; $display("FAIL fill_gap%0d got cycle %0d want %0d", k, gc, c0 + k); end
            end
        end
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL fill_drained_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_stall();
        int n;
        bit ok, was_stall;
        logic [31:0] held_d;
        logic held_l;
        logic [32:0] got, exp;
        do_reset();
        send_record(mk(30), n); push_exp(mk(30), 4);
        send_record(mk(31), n); push_exp(mk(31), 4);
        was_stall = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (was_stall) begin
                checks++;
                if (bus.output_axis_tvalid !== 1'b1 || bus.output_axis_tdata !== held_d || bus.output_axis_tlast !== held_l) begin
                    errors++;
                    $display("FAIL stall_stable got %b/%h/%b want 1/%h/%b", bus.output_axis_tvalid,
                             bus.output_axis_tdata, bus.output_axis_tlast, held_d, held_l);
                end
            end
            bus.output_axis_tready = (t % 2 == 1);
            was_stall = bus.output_axis_tvalid && !bus.output_axis_tready;
            held_d = bus.output_axis_tdata;
            held_l = bus.output_axis_tlast;
            @(posedge aclk);
            #1;
        end
        bus.output_axis_tready = 1'b1;
        wait_obs(8, 20, ok);
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_timeout got %0d beats want 8", obs_q.size());
        end else begin
            checks++;
            if (obs_q.size() !== 8) begin errors++; $display("FAIL stall_count got %0d want 8", obs_q.size()); end
            for (int k = 0; k < 8 && obs_q.size() > 0; k++) begin
                got = obs_q.pop_front(); void'(obs_cyc_q.pop_front()); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL stall_beat%0d got %h want %h", k, got, exp); end
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        logic [127:0] r;
        logic [32:0] got, exp;
        logic [31:0] want;
        do_reset();
        bus.output_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r = mk(20 + i);
            if (i == 1 || i == 3) r[31] = 1'b1;
            send_record(r, n);
            push_exp(r, 4);
        end
        wait_obs(20, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_timeout got %0d beats want 20", obs_q.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                got = obs_q.pop_front(); void'(obs_cyc_q.pop_front()); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", k, got, exp); end
            end
        end
`ifdef TRACE_OVERFLOW_COUNT_EN
        want = 32'd2;
`else
        want = 32'd0;
`endif
        checks++;
        if (overflow_count !== want) begin errors++; $display("FAIL ovf_count got %0d want %0d", overflow_count, want); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        logic [32:0] got, exp;
        do_reset();
        send_record(mk(40), n); push_exp(mk(40), 2);
        send_record(mk(41), n);
        send_record(mk(42), n);
        send_record(mk(43), n);
        checks++;
        if (fifo_level !== 5'd3) begin errors++; $display("FAIL rmid_queued got %0d want 3", fifo_level); end
        bus.output_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        checks++;
        if (bus.output_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b want 0", bus.output_axis_tvalid); end
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", fifo_level); end
        checks++;
        if (bus.input_axis_tready !== 1'b1) begin errors++; $display("FAIL rmid_in_tready got %b want 1", bus.input_axis_tready); end
        send_record(mk(50), n); push_exp(mk(50), 4);
        wait_obs(6, 30, ok);
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (!ok || obs_q.size() !== 6) begin
            errors++;
            $display("FAIL rmid_count got %0d beats want 6", obs_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                got = obs_q.pop_front(); void'(obs_cyc_q.pop_front()); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL rmid_beat%0d got %h want %h", k, got, exp); end
            end
        end
    endtask

    task automatic test_simul();
        int n0, n1, n2;
        bit ok;
        logic [32:0] got, exp;
        int gc;
        do_reset();
        bus.output_axis_tready = 1'b1;
        send_record(mk(60), n0); push_exp(mk(60), 4);
        send_record(mk(61), n1); push_exp(mk(61), 4);
        while (cyc < n0 + 5) begin
            @(posedge aclk);
            #1;
        end
        checks++;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL simul_pre_level got %0d want 1", fifo_level); end
        send_record(mk(62), n2); push_exp(mk(62), 4);
        checks++;
        if (n2 !== n0 + 5) begin errors++; $display("FAIL simul_accept_cycle got %0d want %0d", n2, n0 + 5); end
        checks++;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL simul_level got %0d want 1", fifo_level); end
        wait_obs(12, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL simul_timeout got %0d beats want 12", obs_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                got = obs_q.pop_front(); gc = obs_cyc_q.pop_front(); exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL simul_beat%0d got %h want %h", k, got, exp); end
                checks++;
                if (gc !== n0 + 2 + k) begin errors++; $display("FAIL simul_cycle%0d got %0d want %0d", k, gc, n0 + 2 + k); end
            end
        end
    endtask

    initial begin
        bus.input_axis_tvalid  = 1'b0;
        bus.input_axis_tdata   = '0;
        bus.output_axis_tready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
